// File: rtl/fa_bist_ctrl_pkg.sv
// Shared definitions for the full-adder BIST engine: FSM encodings, vector space
// and the expected-response record.
package fa_bist_ctrl_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int NUM_VECTORS = 8;
   localparam int VEC_W       = 3;

   localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VECTORS - 1);

   typedef struct packed {
      logic sum;
      logic carry;
   } fa_resp_t;

endpackage

// File: rtl/fa_bist_ctrl_golden.sv
// Golden full-adder response for a {a,b,cin} vector, written independently of
// the adder under test so that a shared bug cannot mask itself.
module fa_bist_ctrl_golden
   import fa_bist_ctrl_pkg::*;
(
   input  logic [VEC_W-1:0] vec,
   output fa_resp_t         exp_resp
);

   always_comb begin
      exp_resp       = '0;
      exp_resp.sum   = vec[2] ^ vec[1] ^ vec[0];
      exp_resp.carry = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
   end

endmodule

// File: rtl/fa_bist_ctrl.sv
// Exhaustive self-test sequencer for a 1-bit full adder: walks all eight
// {a,b,cin} vectors, compares against the golden model and records results.
module fa_bist_ctrl
   import fa_bist_ctrl_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int ERR_W         = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             first_fail_valid,
   output logic [2:0]       first_fail_vec,
   output logic             dut_a,
   output logic             dut_b,
   output logic             dut_cin,
   input  logic             dut_sum,
   input  logic             dut_carry,
   output logic [1:0]       dbg_state
);

   localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES);
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   logic [1:0]       state;
   logic [VEC_W-1:0] vec;
   logic [CNT_W-1:0] cnt;
   fa_resp_t         exp_resp;
   logic             mismatch;
   logic             window_end;

   fa_bist_ctrl_golden u_golden (
      .vec      (vec),
      .exp_resp (exp_resp)
   );

   assign mismatch   = (dut_sum != exp_resp.sum) || (dut_carry != exp_resp.carry);
   assign window_end = (cnt == CNT_LAST);
   assign dbg_state  = state;

   // Handshake: start is taken only in IDLE on a rising edge; busy is high from the
   // accepting edge until the last compare, then done pulses for exactly one cycle.
   // Results stay stable from done until the next accepted start clears them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= ST_IDLE;
         vec              <= '0;
         cnt              <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         err_count        <= '0;
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
         dut_a            <= 1'b0;
         dut_b            <= 1'b0;
         dut_cin          <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state                   <= ST_RUN;
                  vec                     <= '0;
                  cnt                     <= '0;
                  busy                    <= 1'b1;
                  pass                    <= 1'b0;
                  err_count               <= '0;
                  first_fail_valid        <= 1'b0;
                  first_fail_vec          <= '0;
                  {dut_a, dut_b, dut_cin} <= '0;
               end
            end
            ST_RUN: begin
               if (window_end) begin
                  cnt <= '0;
                  if (mismatch) begin
                     if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
                     if (!first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_vec   <= vec;
                     end
                  end
                  if (vec == VEC_LAST) begin
                     state                   <= ST_DONE;
                     busy                    <= 1'b0;
                     done                    <= 1'b1;
                     // first_fail_valid tracks any earlier miss, independent of saturation
                     pass                    <= !(first_fail_valid || mismatch);
                     {dut_a, dut_b, dut_cin} <= '0;
                  end else begin
                     vec                     <= vec + 1'b1;
                     {dut_a, dut_b, dut_cin} <= vec + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
